// File: rtl/vga_mem_scheduler.sv
// vga_mem_scheduler: shares sprite/frame memory between pixel fetch and two game writers.
// Define HBLANK_WR_EN to also grant writers during horizontal blanking.
module vga_mem_scheduler #(
  parameter int VBP       = 31,
  parameter int VFP       = 511,
  parameter int GUARD_CYC = 4,
  parameter int AW        = 16,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [9:0]    h_counter,
  input  logic [9:0]    v_counter,
  input  logic          vidon,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  input  logic [1:0]    wr_req,
  input  logic [AW-1:0] wr_addr0,
  input  logic [AW-1:0] wr_addr1,
  input  logic [DW-1:0] wr_data0,
  input  logic [DW-1:0] wr_data1,
  output logic          disp_gnt,
  output logic [1:0]    wr_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          frame_tick,
  output logic          blank_win,
  output logic [7:0]    miss_cnt
);

  localparam logic [9:0] VBP_L = 10'(VBP);
  localparam logic [9:0] VFP_L = 10'(VFP);
  localparam logic [7:0] GLAST = 8'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    ACTIVE,
    GUARD,
    ARB
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [7:0]    gcnt;
  logic [7:0]    gcnt_n;
  logic          last;
  logic          last_n;
  logic          win_c;
  logic          rise;
  logic          close;
  logic          wr_ok;
  logic [1:0]    elig;
  logic [1:0]    pick;
  logic [1:0]    wsel;
  logic [7:0]    miss_n;
  logic          dgnt_n;
  logic [1:0]    wgnt_n;
  logic          en_n;
  logic          we_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;
  logic          unused_in;

  assign unused_in = ^{h_counter, vidon};

  assign win_c = (v_counter >= VFP_L) ||
                 (v_counter <= VBP_L);
  assign rise  = win_c && !blank_win;

  // A writer whose grant is on the outputs still shows its old request.
  assign elig = wr_req & ~wr_gnt;

`ifdef HBLANK_WR_EN
  assign wr_ok = (state == ARB) ||
                 ((state == ACTIVE) && !vidon);
`else
  assign wr_ok = (state == ARB);
`endif

  always_comb begin
    pick = elig;
    if (&elig) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

  assign wsel = (wr_ok && !disp_req) ? pick : 2'b00;

  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    close   = 1'b0;
    unique case (state)
      ACTIVE: begin
        if (rise) begin
          state_n = GUARD;
          gcnt_n  = '0;
        end
      end
      GUARD: begin
        if (!win_c) begin
          state_n = ACTIVE;
          close   = 1'b1;
        end else if (gcnt == GLAST) begin
          state_n = ARB;
        end else begin
          gcnt_n = gcnt + 8'd1;
        end
      end
      ARB: begin
        if (!win_c) begin
          state_n = ACTIVE;
          close   = 1'b1;
        end
      end
      default: state_n = ACTIVE;
    endcase
  end

  always_comb begin
    dgnt_n  = 1'b0;
    wgnt_n  = 2'b00;
    en_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    last_n  = last;
    unique case (1'b1)
      disp_req: begin
        dgnt_n = 1'b1;
        en_n   = 1'b1;
        addr_n = disp_addr;
      end
      wsel[0]: begin
        wgnt_n  = 2'b01;
        en_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = wr_addr0;
        wdata_n = wr_data0;
        last_n  = 1'b0;
      end
      wsel[1]: begin
        wgnt_n  = 2'b10;
        en_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = wr_addr1;
        wdata_n = wr_data1;
        last_n  = 1'b1;
      end
      default: ;
    endcase
  end

  // Missed frame: a live request left ungranted as the window shuts.
  always_comb begin
    miss_n = miss_cnt;
    if (close && |(elig & ~wsel) &&
        (miss_cnt != 8'hFF)) begin
      miss_n = miss_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ACTIVE;
      gcnt       <= '0;
      last       <= 1'b1;
      blank_win  <= 1'b0;
      frame_tick <= 1'b0;
      miss_cnt   <= '0;
      disp_gnt   <= 1'b0;
      wr_gnt     <= 2'b00;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      gcnt       <= gcnt_n;
      last       <= last_n;
      blank_win  <= win_c;
      frame_tick <= rise;
      miss_cnt   <= miss_n;
      disp_gnt   <= dgnt_n;
      wr_gnt     <= wgnt_n;
      mem_en     <= en_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
    end
  end

endmodule

// File: doc/vga_mem_scheduler.md
Name: vga_mem_scheduler

Overview:
- Shares the single-port sprite/frame memory between the pixel-fetch path and two game-logic writers: bird/score (port 0) and pipes (port 1).
- Sequences writer access into the vertical blanking window, using the counters produced by the 640x480 timing generator.
- Produces a frame tick for game-state update.
- Counts frames in which a writer request was still pending when the window closed.

Parameters:
- VBP, 31, last line of top blanking; window open when v_counter <= VBP.
- VFP, 511, first line of bottom blanking; window open when v_counter >= VFP.
- GUARD_CYC, 4, cycles after window opens before any writer grant (display pipeline drain); 1..255.
- AW, 16, memory address width.
- DW, 8, memory data width.

Ports:
- clk  in  1  pixel clock.
- clr_n  in  1  asynchronous reset, active-low.
- h_counter  in  10  horizontal counter from timing generator.
- v_counter  in  10  vertical counter from timing generator.
- vidon  in  1  active-video flag from timing generator.
- disp_req  in  1  pixel-fetch read request (level).
- disp_addr  in  AW  pixel-fetch address.
- wr_req  in  2  writer requests; bit i belongs to writer i.
- wr_addr0, wr_addr1  in  AW  writer addresses.
- wr_data0, wr_data1  in  DW  writer data.
- disp_gnt  out  1  read issued this cycle.
- wr_gnt  out  2  one-hot write-issued pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- frame_tick  out  1  one-cycle pulse at window open.
- blank_win  out  1  registered window flag.
- miss_cnt  out  8  saturating missed-window count.

Behaviour:
- Reset (clr_n low, async): all outputs 0; FSM = ACTIVE; guard counter 0; round-robin pointer = 1, so writer 0 wins first.
- win_c (combinational) = (v_counter >= VFP) || (v_counter <= VBP). blank_win <= win_c.
- frame_tick = 1 for exactly one cycle, on the cycle blank_win first reads 1.
- FSM states:
  - ACTIVE: on win_c rising → GUARD, guard counter cleared.
  - GUARD: counter increments each cycle; when it reaches GUARD_CYC-1 → ARB; if win_c drops → ACTIVE.
  - ARB: if win_c drops → ACTIVE.
- Arbitration is evaluated each cycle; all mem_*/gnt outputs are registered (1-cycle latency from request sample).
  - Priority 1: disp_req=1 → next cycle mem_en=1, mem_we=0, mem_addr=disp_addr, disp_gnt=1. Display always wins, in every state.
  - Priority 2: state==ARB and an eligible writer exists → next cycle mem_en=1, mem_we=1, mem_addr/mem_wdata from that writer, wr_gnt[i]=1.
  - Otherwise: mem_en=0, mem_we=0, gnt=0. Address/data hold their last value.
- Writer i is eligible when wr_req[i]=1 and wr_gnt[i] is currently 0. This masks the stale request visible during the grant cycle.
  - Consequence: one writer alone gets at most 1 write per 2 cycles; two writers alternating can write every cycle.
- Round robin: when both writers are eligible, grant the one not granted last. The pointer updates only on a writer grant.
- Window closing (ARB or GUARD → ACTIVE): a grant already registered completes normally. If any wr_req bit is high at that transition and not being granted, miss_cnt increments, saturating at 255.
- Writers hold wr_req/addr/data stable until they see wr_gnt. The block does not check for protocol violations.

Optional Feature:
- Macro: HBLANK_WR_EN.
- Defined: writer grants are also permitted in state ACTIVE on cycles where vidon=0 and disp_req=0 (horizontal blanking). Priority and masking rules are unchanged. miss_cnt is still evaluated only at the vertical window close.
- Undefined: writers are granted only in ARB.

Test Plan:
- Reset mid-frame (clr_n low at v=200, h=300) → all outputs 0 immediately; after release at v=300, first grant goes to writer 0 when both request in ARB.
- v_counter 510→511 with h sweeping, GUARD_CYC=4, wr_req=01 held → frame_tick single pulse; wr_gnt[0] first high on the 6th cycle after v=511 (1 blank_win lag + 4 guard cycles + 1 output register); grants every 2nd cycle thereafter.
- Both writers requesting continuously in ARB → wr_gnt alternates 01,10,01,…; mem_we=1 every cycle; mem_addr alternates wr_addr0/wr_addr1.
- disp_req=1 for 3 cycles during ARB with writers pending → disp_gnt high 3 cycles, mem_we=0, no wr_gnt; writers resume with round-robin order preserved.
- wr_req[1] held across v_counter 31→32 (window close) without grant → miss_cnt 0→1; repeat 300 frames → miss_cnt saturates at 255.
- With HBLANK_WR_EN: wr_req=01 at v=100, vidon=0, disp_req=0 → wr_gnt[0] next cycle. Without the macro → no grant until the next ARB.
